led_matrix_scan_ctrl: RTL and testbench

Column-multiplexing scan controller for the 5x7 LED matrix that displays the game board. It takes the five 7-bit column patterns produced by game selection and game logic. It strobes one column at a time with anti-ghost blanking and latches the patterns once per frame so the display never tears. It also applies a per-pixel blink mask, used for the cursor and hit markers.

---
 rtl/led_matrix_scan_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_led_matrix_scan_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan_ctrl.sv
// Column-multiplexed scan controller for the 5x7 game-board LED matrix.
// One column is strobed per slot; each slot opens with a short all-off
// blanking window so the previous column's rows never ghost into the next.
// Column patterns and the blink mask are latched once per frame so the
// picture never tears, and a slow blink phase hides masked pixels.
module led_matrix_scan_ctrl #(
  parameter int SCAN_DIV       = 10000,
  parameter int BLANK_CYCLES   = 16,
  parameter int BLINK_FRAMES   = 50,
  parameter bit COL_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [6:0]  col1_in,
  input  logic [6:0]  col2_in,
  input  logic [6:0]  col3_in,
  input  logic [6:0]  col4_in,
  input  logic [6:0]  col5_in,
  input  logic [34:0] blink_mask,
  output logic [4:0]  col_sel,
  output logic [6:0]  row_out,
  output logic        frame_start,
  output logic        blink_phase
);

  localparam int DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FC_W       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int DIV_LAST_I = SCAN_DIV - 1;
  localparam int FC_LAST_I  = BLINK_FRAMES - 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_LAST_I[DIV_W-1:0];
  localparam logic [DIV_W-1:0] BLANK_LIM = BLANK_CYCLES[DIV_W-1:0];
  localparam logic [FC_W-1:0]  FC_LAST   = FC_LAST_I[FC_W-1:0];
  localparam logic [2:0]       COL_LAST  = 3'd4;
  // Strobe value with no column enabled; XOR with a one-hot gives the
  // correctly polarised strobe for either column driver type.
  localparam logic [4:0]       COL_OFF   = COL_ACTIVE_LOW ? 5'b11111 : 5'b00000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
  logic [2:0]        col_idx_reg, col_idx_next;
  logic [FC_W-1:0]   frame_cnt_reg, frame_cnt_next;
  logic              blink_phase_reg, blink_phase_next;

  // frame_event: a frame-start cycle (shadows reload, pulse emitted).
  // frame_done: a frame actually completed (4->0 wrap); only these count
  // towards the blink period, a restart from IDLE closes no frame.
  logic              frame_event;
  logic              frame_done;

  logic [6:0]        col_in      [5];
  logic [6:0]        mask_in     [5];
  logic [6:0]        shadow_reg  [5];
  logic [6:0]        shadow_next [5];
  logic [6:0]        mask_reg    [5];
  logic [6:0]        mask_next   [5];

  logic [6:0]        sel_pat;
  logic [6:0]        sel_mask;
  logic [4:0]        col_active;
  logic [4:0]        col_sel_reg, col_sel_next;
  logic [6:0]        row_out_reg, row_out_next;
  logic              frame_start_reg, frame_start_next;

  assign col_in[0] = col1_in;
  assign col_in[1] = col2_in;
  assign col_in[2] = col3_in;
  assign col_in[3] = col4_in;
  assign col_in[4] = col5_in;

  // Next-state logic: slot/column sequencing and frame-start detection.
  always_comb begin
    state_next   = state_reg;
    div_cnt_next = div_cnt_reg;
    col_idx_next = col_idx_reg;
    frame_event  = 1'b0;
    frame_done   = 1'b0;
    if (!enable) begin
      // Disable wins over any wrap or frame start in the same cycle.
      state_next   = IDLE;
      div_cnt_next = '0;
      col_idx_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          div_cnt_next = '0;
          col_idx_next = '0;
          frame_event  = 1'b1;
        end
        default: begin
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_next = '0;
            if (col_idx_reg == COL_LAST) begin
              col_idx_next = '0;
              frame_event  = 1'b1;
              frame_done   = 1'b1;
            end else begin
              col_idx_next = col_idx_reg + 3'd1;
            end
          end else begin
            div_cnt_next = div_cnt_reg + 1'b1;
          end
        end
      endcase
      // Blanking covers the first BLANK_CYCLES counts of every slot; with
      // zero blanking the compare is never true and BLANK is skipped.
      state_next = (div_cnt_next < BLANK_LIM) ? BLANK : DRIVE;
    end
  end

  // Blink timing: count completed frames, toggle the phase every period.
  always_comb begin
    frame_cnt_next   = frame_cnt_reg;
    blink_phase_next = blink_phase_reg;
    if (frame_done) begin
      if (frame_cnt_reg == FC_LAST) begin
        frame_cnt_next   = '0;
        blink_phase_next = ~blink_phase_reg;
      end else begin
        frame_cnt_next = frame_cnt_reg + 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_col
      assign mask_in[gi]     = blink_mask[7*gi +: 7];
      assign shadow_next[gi] = frame_event ? col_in[gi]  : shadow_reg[gi];
      assign mask_next[gi]   = frame_event ? mask_in[gi] : mask_reg[gi];
      assign col_active[gi]  = (state_next == DRIVE) && (col_idx_next == 3'(gi));

      // Frame-synchronous copy of this column's pattern and blink mask.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          shadow_reg[gi] <= '0;
          mask_reg[gi]   <= '0;
        end else begin
          shadow_reg[gi] <= shadow_next[gi];
          mask_reg[gi]   <= mask_next[gi];
        end
      end
    end
  endgenerate

  // Pick the pattern and mask of the column about to be driven.
  always_comb begin
    sel_pat  = '0;
    sel_mask = '0;
    for (int i = 0; i < 5; i++) begin
      if (col_idx_next == 3'(i)) begin
        sel_pat  = shadow_next[i];
        sel_mask = mask_next[i];
      end
    end
  end

  // Output decode from next-state values so the registered outputs line up
  // with the state of the same cycle. Masked pixels go dark in phase 0.
  always_comb begin
    col_sel_next     = col_active ^ COL_OFF;
    row_out_next     = '0;
    frame_start_next = frame_event;
    if (state_next == DRIVE) begin
      row_out_next = sel_pat & ~(sel_mask & {7{~blink_phase_next}});
    end
  end

  // Scan state, slot counter and column index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      div_cnt_reg <= '0;
      col_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      div_cnt_reg <= div_cnt_next;
      col_idx_reg <= col_idx_next;
    end
  end

  // Frame counter and blink phase; these survive an enable drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b1;
    end else begin
      frame_cnt_reg   <= frame_cnt_next;
      blink_phase_reg <= blink_phase_next;
    end
  end

  // Registered matrix drive outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_sel_reg     <= COL_OFF;
      row_out_reg     <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      col_sel_reg     <= col_sel_next;
      row_out_reg     <= row_out_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign col_sel     = col_sel_reg;
  assign row_out     = row_out_reg;
  assign frame_start = frame_start_reg;
  assign blink_phase = blink_phase_reg;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Self-checking bench for led_matrix_scan_ctrl (SCAN_DIV=8, BLANK_CYCLES=2,
// BLINK_FRAMES=2, active-low columns). Cycle n is the period following
// clock edge n, counted from the first edge of a scenario.
module tb_led_matrix_scan_ctrl;

  typedef struct {
    string      name;
    logic [4:0] cs;
    logic [6:0] row;
    logic       fs;
    logic       bp;
  } exp_t;

  typedef struct {
    int         sc;
    int         cyc;
    logic [4:0] cs;
    logic [6:0] row;
    logic       fs;
    logic       bp;
  } vec_t;

  logic        clk;
  logic        clk_run;
  logic        reset;
  logic        enable;
  logic [6:0]  col1_in, col2_in, col3_in, col4_in, col5_in;
  logic [34:0] blink_mask;
  logic [4:0]  col_sel;
  logic [6:0]  row_out;
  logic        frame_start;
  logic        blink_phase;

  int   n_vec;
  int   n_err;
  exp_t sb[$];
  vec_t tbl[$];

  led_matrix_scan_ctrl #(
    .SCAN_DIV      (8),
    .BLANK_CYCLES  (2),
    .BLINK_FRAMES  (2),
    .COL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .col1_in    (col1_in),
    .col2_in    (col2_in),
    .col3_in    (col3_in),
    .col4_in    (col4_in),
    .col5_in    (col5_in),
    .blink_mask (blink_mask),
    .col_sel    (col_sel),
    .row_out    (row_out),
    .frame_start(frame_start),
    .blink_phase(blink_phase)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  function automatic vec_t mk(int sc, int cyc, logic [4:0] cs, logic [6:0] row,
                              logic fs, logic bp);
    vec_t v;
    v.sc = sc; v.cyc = cyc; v.cs = cs; v.row = row; v.fs = fs; v.bp = bp;
    return v;
  endfunction

  function automatic exp_t mk_exp(string name, logic [4:0] cs, logic [6:0] row,
                                  logic fs, logic bp);
    exp_t e;
    e.name = name; e.cs = cs; e.row = row; e.fs = fs; e.bp = bp;
    return e;
  endfunction

  // Closed-form expectation for the free-running scenario 0: 40-cycle
  // frames, 8-cycle slots, 2 blank counts per slot, col3 changed at cycle
  // 12 (visible from frame 1), col5 row0 blinking off in frames 2 and 3.
  function automatic exp_t model0(int t);
    exp_t       e;
    int         f, s, d;
    logic [6:0] pat;
    logic [4:0] one;
    f = t / 40;
    s = (t % 40) / 8;
    d = t % 8;
    e.name = $sformatf("scan_t%0d", t);
    e.fs   = (t % 40 == 0);
    e.bp   = (f == 2 || f == 3) ? 1'b0 : 1'b1;
    if (d < 2) begin
      e.cs  = 5'b11111;
      e.row = 7'b0000000;
    end else begin
      case (s)
        0:       pat = 7'b0111100;
        1:       pat = 7'b0011101;
        2:       pat = (f >= 1) ? 7'b0000001 : 7'b0110101;
        3:       pat = 7'b1000111;
        default: pat = 7'b1110111;
      endcase
      if (s == 4 && !e.bp) pat[0] = 1'b0;
      one   = 5'b00001 << s;
      e.cs  = ~one;
      e.row = pat;
    end
    return e;
  endfunction

  function automatic logic en_at(int sc, int t);
    case (sc)
      1:       return !(t >= 101 && t <= 109);
      2:       return (t != 40);
      default: return 1'b1;
    endcase
  endfunction

  task automatic apply_inputs(int sc, int t);
    col1_in    = (sc == 1 && t >= 105) ? 7'b1010101 : 7'b0111100;
    col2_in    = 7'b0011101;
    col3_in    = (sc == 0 && t >= 12) ? 7'b0000001 : 7'b0110101;
    col4_in    = 7'b1000111;
    col5_in    = 7'b1110111;
    blink_mask = 35'd1 << 28;
  endtask

  task automatic compare(exp_t e);
    n_vec++;
    if (col_sel !== e.cs || row_out !== e.row || frame_start !== e.fs ||
        blink_phase !== e.bp) begin
      n_err++;
      $display("FAIL %s: got col_sel=%b row_out=%b frame_start=%b blink_phase=%b, want %b %b %b %b",
               e.name, col_sel, row_out, frame_start, blink_phase, e.cs, e.row, e.fs, e.bp);
    end else begin
      $display("ok   %s: col_sel=%b row_out=%b frame_start=%b blink_phase=%b",
               e.name, col_sel, row_out, frame_start, blink_phase);
    end
  endtask

  task automatic do_reset();
    enable = 1'b0;
    apply_inputs(-1, 0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Drive one scenario cycle by cycle; expectations are queued at the edge
  // and checked on the following falling edge.
  task automatic run_scenario(int sc, int ncyc);
    exp_t e;
    for (int t = 0; t < ncyc; t++) begin
      enable = en_at(sc, t);
      apply_inputs(sc, t);
      @(posedge clk);
      if (sc == 0) sb.push_back(model0(t));
      foreach (tbl[i]) begin
        if (tbl[i].sc == sc && tbl[i].cyc == t)
          sb.push_back(mk_exp($sformatf("s%0d_c%0d", sc, t),
                              tbl[i].cs, tbl[i].row, tbl[i].fs, tbl[i].bp));
      end
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        compare(e);
      end
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    clk_run = 1'b0;

    // Spot checks: scenario, cycle, col_sel, row_out, frame_start, blink_phase.
    tbl.push_back(mk(0,   0, 5'b11111, 7'b0000000, 1'b1, 1'b1));
    tbl.push_back(mk(0,   2, 5'b11110, 7'b0111100, 1'b0, 1'b1));
    tbl.push_back(mk(0,  10, 5'b11101, 7'b0011101, 1'b0, 1'b1));
    tbl.push_back(mk(0,  23, 5'b11011, 7'b0110101, 1'b0, 1'b1));
    tbl.push_back(mk(0,  34, 5'b01111, 7'b1110111, 1'b0, 1'b1));
    tbl.push_back(mk(0,  40, 5'b11111, 7'b0000000, 1'b1, 1'b1));
    tbl.push_back(mk(0,  58, 5'b11011, 7'b0000001, 1'b0, 1'b1));
    tbl.push_back(mk(0,  80, 5'b11111, 7'b0000000, 1'b1, 1'b0));
    tbl.push_back(mk(0, 114, 5'b01111, 7'b1110110, 1'b0, 1'b0));
    tbl.push_back(mk(0, 160, 5'b11111, 7'b0000000, 1'b1, 1'b1));
    tbl.push_back(mk(0, 194, 5'b01111, 7'b1110111, 1'b0, 1'b1));
    // Enable dropped mid-DRIVE in a hidden-phase frame, then re-enabled.
    tbl.push_back(mk(1, 100, 5'b11011, 7'b0110101, 1'b0, 1'b0));
    tbl.push_back(mk(1, 101, 5'b11111, 7'b0000000, 1'b0, 1'b0));
    tbl.push_back(mk(1, 109, 5'b11111, 7'b0000000, 1'b0, 1'b0));
    tbl.push_back(mk(1, 110, 5'b11111, 7'b0000000, 1'b1, 1'b0));
    tbl.push_back(mk(1, 112, 5'b11110, 7'b1010101, 1'b0, 1'b0));
    tbl.push_back(mk(1, 150, 5'b11111, 7'b0000000, 1'b1, 1'b0));
    tbl.push_back(mk(1, 186, 5'b01111, 7'b1110110, 1'b0, 1'b0));
    tbl.push_back(mk(1, 190, 5'b11111, 7'b0000000, 1'b1, 1'b1));
    tbl.push_back(mk(1, 194, 5'b11110, 7'b1010101, 1'b0, 1'b1));
    // Enable low exactly on the frame wrap suppresses that frame start.
    tbl.push_back(mk(2,  39, 5'b01111, 7'b1110111, 1'b0, 1'b1));
    tbl.push_back(mk(2,  40, 5'b11111, 7'b0000000, 1'b0, 1'b1));
    tbl.push_back(mk(2,  41, 5'b11111, 7'b0000000, 1'b1, 1'b1));
    tbl.push_back(mk(2,  43, 5'b11110, 7'b0111100, 1'b0, 1'b1));
    // Run-up to the asynchronous reset, then restart after it.
    tbl.push_back(mk(3,  20, 5'b11011, 7'b0110101, 1'b0, 1'b1));
    tbl.push_back(mk(4,   0, 5'b11111, 7'b0000000, 1'b1, 1'b1));
    tbl.push_back(mk(4,   1, 5'b11111, 7'b0000000, 1'b0, 1'b1));
    tbl.push_back(mk(4,   2, 5'b11110, 7'b0111100, 1'b0, 1'b1));
    tbl.push_back(mk(4,  10, 5'b11101, 7'b0011101, 1'b0, 1'b1));

    // Reset with the clock stopped: outputs must settle without an edge.
    apply_inputs(-1, 0);
    enable = 1'b1;
    reset  = 1'b1;
    #1;
    reset = 1'b0;
    #2;
    compare(mk_exp("reset_no_clock", 5'b11111, 7'b0000000, 1'b0, 1'b1));
    reset = 1'b1;
    #2;
    compare(mk_exp("release_no_clock", 5'b11111, 7'b0000000, 1'b0, 1'b1));

    enable  = 1'b0;
    clk_run = 1'b1;
    repeat (2) @(negedge clk);
    compare(mk_exp("idle_enable_low", 5'b11111, 7'b0000000, 1'b0, 1'b1));

    do_reset();
    run_scenario(0, 200);
    do_reset();
    run_scenario(1, 196);
    do_reset();
    run_scenario(2, 46);
    do_reset();
    run_scenario(3, 21);

    // Reset asserted between edges while column 3 is being driven.
    #1;
    reset = 1'b0;
    #1;
    compare(mk_exp("async_reset_mid_drive", 5'b11111, 7'b0000000, 1'b0, 1'b1));
    #1;
    reset = 1'b1;
    run_scenario(4, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
